// File: rtl/openofdm_rx_byte_packer_pkg.sv
// Shared encodings and word-layout offsets for the rx byte packer.
package openofdm_rx_byte_packer_pkg;

  // Word type tag carried on m_type
  typedef enum logic [1:0] {
    TypeHdr  = 2'd0,
    TypeData = 2'd1,
    TypeTrl  = 2'd2
  } m_type_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StData    = 3'd1,
    StWaitFcs = 3'd2,
    StFlush   = 3'd3,
    StTrailer = 3'd4
  } state_e;

  // Header word fields
  localparam int unsigned HdrLenLsb      = 0;
  localparam int unsigned HdrRateLsb     = 16;
  localparam int unsigned HdrAggrBit     = 24;
  localparam int unsigned HdrAggrLastBit = 25;
  localparam int unsigned HdrSgiBit      = 26;
  // Trailer word fields
  localparam int unsigned TrlFcsOkBit    = 0;
  localparam int unsigned TrlAbortBit    = 1;
  localparam int unsigned TrlOvfBit      = 2;
  localparam int unsigned TrlCntLsb      = 16;
  // Sequence number, common to header and trailer
  localparam int unsigned SeqLsb         = 48;

  // FIFO entry: {last, type, keep, word}
  localparam int unsigned FifoWidth = 64 + 8 + 2 + 1;

  // Contiguous byte-valid mask for n filled lanes (n = 1..8)
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'h1 << n) - 9'h1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/openofdm_rx_word_fifo.sv
// Synchronous FIFO with free-entry count; output reads as zero while empty.
module openofdm_rx_word_fifo #(
  parameter int unsigned DepthLog2 = 2,
  parameter int unsigned Width     = 75
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [DepthLog2:0] free_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam int unsigned CntW  = DepthLog2 + 1;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full, do_push, do_pop;

  // Pointer/count update; a pop frees the slot a same-cycle push may take
  always_comb begin
    full     = (count_q == CntW'(Depth));
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + DepthLog2'(do_push);
    rd_ptr_d = rd_ptr_q + DepthLog2'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign free_o  = CntW'(Depth) - count_q;

endmodule

// File: rtl/openofdm_rx_byte_packer.sv
// Packs receiver header/byte/FCS events into header, data and trailer 64-bit words.
module openofdm_rx_byte_packer
  import openofdm_rx_byte_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic        ht_unsupport,
  input  logic [7:0]  pkt_rate,
  input  logic [15:0] pkt_len,
  input  logic        ht_aggr,
  input  logic        ht_aggr_last,
  input  logic        ht_sgi,
  input  logic        byte_out_strobe,
  input  logic [7:0]  byte_out,
  input  logic        fcs_out_strobe,
  input  logic        fcs_ok,
  input  logic        pkt_abort,
  output logic [63:0] m_word,
  output logic [7:0]  m_keep,
  output logic [1:0]  m_type,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow_sticky,
  input  logic        clear_overflow,
  output logic [15:0] pkt_count
);

  localparam int unsigned FreeW = FIFO_DEPTH_LOG2 + 2;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d, seq_q, seq_d, idx_q, idx_d, pkt_count_q, pkt_count_d;
  logic [63:0] acc_q, acc_d;
  logic        fcs_ok_q, fcs_ok_d, aborted_q, aborted_d, pkt_ovf_q, pkt_ovf_d;
  logic        ovf_sticky_q, ovf_sticky_d;

  logic        push, need2, accept, pop, hdr_ok, abort_ev;
  logic [63:0] push_word, acc_new;
  logic [7:0]  push_keep;
  m_type_e     push_type;
  logic        push_last;
  logic [2:0]  lane;
  logic [15:0] idx_new;
  logic [FIFO_DEPTH_LOG2:0] fifo_free;
  logic [FreeW-1:0]         free_eff;
  logic [FifoWidth-1:0]     fifo_rdata;

  assign pop      = m_valid & m_ready;
  assign hdr_ok   = pkt_header_valid_strobe & pkt_header_valid & ~ht_unsupport;
  assign abort_ev = pkt_abort | hdr_ok;
  assign lane     = idx_q[2:0];

  // Packet FSM next-state, word assembly and FIFO admission
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    seq_d        = seq_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    fcs_ok_d     = fcs_ok_q;
    aborted_d    = aborted_q;
    pkt_ovf_d    = pkt_ovf_q;
    pkt_count_d  = pkt_count_q;
    ovf_sticky_d = clear_overflow ? 1'b0 : ovf_sticky_q;
    push         = 1'b0;
    need2        = 1'b1;
    push_word    = '0;
    push_keep    = 8'hFF;
    push_type    = TypeData;
    push_last    = 1'b0;
    acc_new      = acc_q;
    acc_new[{lane, 3'b000} +: 8] = byte_out;
    idx_new      = idx_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (hdr_ok) begin
          push      = 1'b1;
          push_type = TypeHdr;
          push_word[HdrLenLsb +: 16] = pkt_len;
          push_word[HdrRateLsb +: 8] = pkt_rate;
          push_word[HdrAggrBit]      = ht_aggr;
          push_word[HdrAggrLastBit]  = ht_aggr_last;
          push_word[HdrSgiBit]       = ht_sgi;
          push_word[SeqLsb +: 16]    = pkt_count_q;
          pkt_count_d = pkt_count_q + 16'd1;
          seq_d       = pkt_count_q;
          len_d       = pkt_len;
          idx_d       = '0;
          acc_d       = '0;
          fcs_ok_d    = 1'b0;
          aborted_d   = 1'b0;
          pkt_ovf_d   = 1'b0;
          state_d     = (pkt_len == 16'd0) ? StWaitFcs : StData;
        end
      end
      StData: begin
        if (abort_ev) begin
          aborted_d = 1'b1;
          fcs_ok_d  = 1'b0;
          state_d   = (lane != 3'd0) ? StFlush : StTrailer;
        end else if (byte_out_strobe) begin
          idx_d = idx_new;
          acc_d = acc_new;
          if (lane == 3'd7 || idx_new == len_q) begin
            push      = 1'b1;
            push_word = acc_new;
            push_keep = keep_mask({1'b0, lane} + 4'd1);
            acc_d     = '0;
          end
          if (idx_new == len_q) begin
            // Last byte and FCS result may coincide; trailer follows next cycle
            if (fcs_out_strobe) begin
              fcs_ok_d = fcs_ok;
              state_d  = StTrailer;
            end else begin
              state_d  = StWaitFcs;
            end
          end
        end
      end
      StWaitFcs: begin
        if (abort_ev) begin
          aborted_d = 1'b1;
          fcs_ok_d  = 1'b0;
          state_d   = StTrailer;
        end else if (fcs_out_strobe) begin
          fcs_ok_d = fcs_ok;
          state_d  = StTrailer;
        end
      end
      StFlush: begin
        push      = 1'b1;
        push_word = acc_q;
        push_keep = keep_mask({1'b0, lane});
        acc_d     = '0;
        state_d   = StTrailer;
      end
      StTrailer: begin
        push      = 1'b1;
        need2     = 1'b0;
        push_type = TypeTrl;
        push_last = 1'b1;
        push_word[TrlFcsOkBit]     = fcs_ok_q & ~aborted_q;
        push_word[TrlAbortBit]     = aborted_q;
        push_word[TrlOvfBit]       = pkt_ovf_q;
        push_word[TrlCntLsb +: 16] = idx_q;
        push_word[SeqLsb +: 16]    = seq_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Header/data keep one slot in reserve so the trailer always fits
    free_eff = FreeW'(fifo_free) + FreeW'(pop);
    accept   = need2 ? (free_eff >= FreeW'(2)) : (free_eff >= FreeW'(1));
    if (push && !accept) begin
      ovf_sticky_d = 1'b1;
      pkt_ovf_d    = 1'b1;
    end
  end

  // Packer state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      seq_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      fcs_ok_q     <= 1'b0;
      aborted_q    <= 1'b0;
      pkt_ovf_q    <= 1'b0;
      pkt_count_q  <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      seq_q        <= seq_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      fcs_ok_q     <= fcs_ok_d;
      aborted_q    <= aborted_d;
      pkt_ovf_q    <= pkt_ovf_d;
      pkt_count_q  <= pkt_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  openofdm_rx_word_fifo #(
    .DepthLog2 (FIFO_DEPTH_LOG2),
    .Width     (FifoWidth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push & accept),
    .wdata_i ({push_last, push_type, push_keep, push_word}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (m_valid),
    .free_o  (fifo_free)
  );

  assign m_word          = fifo_rdata[63:0];
  assign m_keep          = fifo_rdata[71:64];
  assign m_type          = fifo_rdata[73:72];
  assign m_last          = fifo_rdata[74];
  assign overflow_sticky = ovf_sticky_q;
  assign pkt_count       = pkt_count_q;

endmodule

// File: tb/tb_openofdm_rx_byte_packer.sv
// Scoreboard bench for the rx byte packer: stimulus queues expected words, monitor checks them.
module tb_openofdm_rx_byte_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_header_valid_strobe = 1'b0, pkt_header_valid = 1'b0, ht_unsupport = 1'b0;
  logic [7:0]  pkt_rate = '0;
  logic [15:0] pkt_len = '0;
  logic        ht_aggr = 1'b0, ht_aggr_last = 1'b0, ht_sgi = 1'b0;
  logic        byte_out_strobe = 1'b0;
  logic [7:0]  byte_out = '0;
  logic        fcs_out_strobe = 1'b0, fcs_ok = 1'b0, pkt_abort = 1'b0;
  logic [63:0] m_word;
  logic [7:0]  m_keep;
  logic [1:0]  m_type;
  logic        m_last, m_valid;
  logic        m_ready = 1'b1;
  logic        overflow_sticky;
  logic        clear_overflow = 1'b0;
  logic [15:0] pkt_count;

  openofdm_rx_byte_packer #(.FIFO_DEPTH_LOG2(2)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_header_valid        (pkt_header_valid),
    .ht_unsupport            (ht_unsupport),
    .pkt_rate                (pkt_rate),
    .pkt_len                 (pkt_len),
    .ht_aggr                 (ht_aggr),
    .ht_aggr_last            (ht_aggr_last),
    .ht_sgi                  (ht_sgi),
    .byte_out_strobe         (byte_out_strobe),
    .byte_out                (byte_out),
    .fcs_out_strobe          (fcs_out_strobe),
    .fcs_ok                  (fcs_ok),
    .pkt_abort               (pkt_abort),
    .m_word                  (m_word),
    .m_keep                  (m_keep),
    .m_type                  (m_type),
    .m_last                  (m_last),
    .m_valid                 (m_valid),
    .m_ready                 (m_ready),
    .overflow_sticky         (overflow_sticky),
    .clear_overflow          (clear_overflow),
    .pkt_count               (pkt_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] word;
    logic [7:0]  keep;
    logic [1:0]  typ;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic toggle_en = 1'b0;

  logic        hold_pend = 1'b0;
  logic [63:0] hold_word;
  logic [10:0] hold_ctl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic exp_word(input logic [63:0] w, input logic [7:0] k, input logic [1:0] t,
                          input logic l);
    exp_t e;
    e.word = w;
    e.keep = k;
    e.typ  = t;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic exp_hdr(input logic [63:0] w);
    exp_word(w, 8'hFF, 2'd0, 1'b0);
  endtask

  task automatic exp_data(input logic [63:0] w, input logic [7:0] k);
    exp_word(w, k, 2'd1, 1'b0);
  endtask

  task automatic exp_trl(input logic [63:0] w);
    exp_word(w, 8'hFF, 2'd2, 1'b1);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    if (toggle_en) m_ready = ~m_ready;
  endtask

  task automatic send_hdr(input logic [15:0] len, input logic [7:0] rate, input logic aggr,
                          input logic aggr_last, input logic sgi, input logic valid,
                          input logic unsup);
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid = valid;
    ht_unsupport = unsup;
    pkt_len = len;
    pkt_rate = rate;
    ht_aggr = aggr;
    ht_aggr_last = aggr_last;
    ht_sgi = sgi;
    tick();
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid = 1'b0;
    ht_unsupport = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fcs_st, input logic fcs_v);
    byte_out_strobe = 1'b1;
    byte_out = b;
    fcs_out_strobe = fcs_st;
    fcs_ok = fcs_v;
    tick();
    byte_out_strobe = 1'b0;
    fcs_out_strobe = 1'b0;
    fcs_ok = 1'b0;
  endtask

  task automatic send_fcs(input logic v);
    fcs_out_strobe = 1'b1;
    fcs_ok = v;
    tick();
    fcs_out_strobe = 1'b0;
    fcs_ok = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      tick();
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares popped words against the scoreboard and checks stall stability
  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_word", m_word, hold_word);
        check("stall_ctl", 64'({m_valid, m_keep, m_type, m_last}), 64'({1'b1, hold_ctl}));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %h type %0d, want no word", m_word, m_type);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", m_word, e.word);
          check("keep_type_last", 64'({m_keep, m_type, m_last}), 64'({e.keep, e.typ, e.last}));
        end
      end
      hold_pend = m_valid && !m_ready;
      hold_word = m_word;
      hold_ctl  = {m_keep, m_type, m_last};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_word", m_word, 64'd0);
    check("rst_ctl", 64'({m_keep, m_type, m_last}), 64'd0);
    check("rst_count", 64'(pkt_count), 64'd0);
    check("rst_ovf", 64'(overflow_sticky), 64'd0);
    reset = 1'b0;
    tick();

    // 13-byte packet, two data words, good FCS
    exp_hdr(64'h0000_0000_040B_000D);
    exp_data(64'h0807_0605_0403_0201, 8'hFF);
    exp_data(64'h0000_000D_0C0B_0A09, 8'h1F);
    exp_trl(64'h0000_0000_000D_0001);
    send_hdr(16'd13, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 13; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_fcs(1'b1);
    drain("drain_len13");

    // 16 bytes: exactly two full words, bad FCS
    exp_hdr(64'h0001_0000_0000_0010);
    exp_data(64'h1716_1514_1312_1110, 8'hFF);
    exp_data(64'h1F1E_1D1C_1B1A_1918, 8'hFF);
    exp_trl(64'h0001_0000_0010_0000);
    send_hdr(16'd16, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0);
    send_fcs(1'b0);
    drain("drain_len16");

    // Zero-length packet with aggregation flags
    exp_hdr(64'h0002_0000_0300_0000);
    exp_trl(64'h0002_0000_0000_0001);
    send_hdr(16'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_fcs(1'b1);
    drain("drain_len0");

    // Abort after 5 of 20 bytes
    exp_hdr(64'h0003_0000_0000_0014);
    exp_data(64'h0000_00A5_A4A3_A2A1, 8'h1F);
    exp_trl(64'h0003_0000_0005_0002);
    send_hdr(16'd20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) send_byte(8'(8'hA0 + i), 1'b0, 1'b0);
    pkt_abort = 1'b1;
    tick();
    pkt_abort = 1'b0;
    drain("drain_abort");

    // Next header after abort; last byte coincides with FCS strobe
    exp_hdr(64'h0004_0000_0000_0001);
    exp_data(64'h0000_0000_0000_005A, 8'h01);
    exp_trl(64'h0004_0000_0001_0001);
    send_hdr(16'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b1);
    drain("drain_same_cycle");
    check("count_after5", 64'(pkt_count), 64'd5);

    // Rejected headers and stray strobes in IDLE produce nothing
    send_hdr(16'd4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_hdr(16'd4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    send_fcs(1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("ignored_count", 64'(pkt_count), 64'd5);
    check("ignored_valid", 64'(m_valid), 64'd0);

    // m_ready toggling every cycle
    exp_hdr(64'h0005_0000_0000_0009);
    exp_data(64'h3837_3635_3433_3231, 8'hFF);
    exp_data(64'h0000_0000_0000_0039, 8'h01);
    exp_trl(64'h0005_0000_0009_0001);
    toggle_en = 1'b1;
    send_hdr(16'd9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h30 + i), 1'b0, 1'b0);
    send_byte(8'h39, 1'b1, 1'b1);
    drain("drain_toggle");
    toggle_en = 1'b0;
    m_ready = 1'b1;

    // Overflow with sink stalled: header + two data words fit, trailer uses the last slot
    m_ready = 1'b0;
    exp_hdr(64'h0006_0000_0000_0040);
    exp_data(64'h0706_0504_0302_0100, 8'hFF);
    exp_data(64'h0F0E_0D0C_0B0A_0908, 8'hFF);
    exp_trl(64'h0006_0000_0040_0005);
    send_hdr(16'd64, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_fcs(1'b1);
    tick();
    check("ovf_set", 64'(overflow_sticky), 64'd1);
    m_ready = 1'b1;
    drain("drain_overflow");
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_clear", 64'(overflow_sticky), 64'd0);

    // Reset in the middle of a packet discards everything
    m_ready = 1'b0;
    send_hdr(16'd30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hC0, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(m_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    reset = 1'b0;
    check("mid_rst_count", 64'(pkt_count), 64'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_valid", 64'(m_valid), 64'd0);

    // Fresh packet after reset restarts the sequence at 0
    exp_hdr(64'h0000_0000_0000_0002);
    exp_data(64'h0000_0000_0000_EFBE, 8'h03);
    exp_trl(64'h0000_0000_0002_0001);
    send_hdr(16'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0);
    send_byte(8'hEF, 1'b0, 1'b0);
    send_fcs(1'b1);
    drain("drain_post_rst");
    check("final_count", 64'(pkt_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
